seven_seg_tdm_receiver: RTL
===========================

Name: seven_seg_tdm_receiver

Overview:
- Receive end of the 8-digit time-multiplexed seven-segment display interface. Samples the active-low segment lines (CA..CG) and anode lines (AN7..AN0) that the display multiplexer drives.
- Decodes each dwelling digit back to a hex nibble and reassembles the 32-bit value shown on the display.
- Used as a loop-back checker on the board and as a scoreboard front-end in system benches of the counter/display path.

Parameters:
- SETTLE_CYCLES, 16: consecutive clk_in cycles {seg, an} must be unchanged before a digit is captured. Minimum 2.
- FRAME_TIMEOUT, 1000000: clk_in cycles without any capture before the partial frame is discarded and frame_valid drops.

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- seg_n  input  7  segment lines, active low; seg_n[0]=CA … seg_n[6]=CG
- an_n  input  8  anode lines, active low; an_n[k]=ANk, digit k carries value[4k+3:4k]
- value  output  32  last completely received frame
- frame_valid  output  1  value holds a frame that is not stale
- frame_pulse  output  1  one-cycle strobe when value is updated
- digit_mask  output  8  digits captured so far in the current frame
- decode_error  output  1  one-cycle strobe on an unrecognised segment pattern

Behaviour:
- Reset values: value=0, frame_valid=0, frame_pulse=0, digit_mask=0, decode_error=0. Synchronisers, counters and digit registers are cleared. Reset mid-frame discards all partial data.
- Input capture: seg_n and an_n pass through a 2-FF synchroniser (2-cycle latency). All further logic uses the synchronised copies.
- Anode valid: exactly one bit of an_n is 0. All-ones (blanked) or multiple-low is invalid and never captured.
- Stability counter:
  - Cleared when synchronised {seg_n, an_n} differs from the previous cycle; otherwise increments, saturating.
  - Capture fires exactly once per dwell, on the cycle the counter reaches SETTLE_CYCLES-1 with a valid anode.
  - Dwells shorter than SETTLE_CYCLES are ignored.
- Decode table (lit segments, a=CA): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
  - Match: nibble is written to digit register k and digit_mask[k] is set.
  - No match: decode_error pulses for one cycle; register and mask are unchanged.
- Re-capture of a digit already in the mask overwrites the nibble (latest wins); the mask is unchanged.
- Frame completion:
  - If digit_mask reaches 8'hFF at the capture edge, then on the next edge value is loaded atomically from all 8 digit registers, frame_pulse=1 for one cycle, frame_valid=1, and digit_mask clears to 0.
  - A capture in that same cycle starts the new frame (its mask bit is set after the clear).
- Timeout counter:
  - Reset by every successful capture.
  - At FRAME_TIMEOUT: digit_mask clears, frame_valid drops to 0, value is held, no pulse. The counter then saturates until the next capture.
- Frame order is irrelevant; any 8 distinct digits complete a frame.
- Latency, last anode settle to frame_pulse: 2 (sync) + SETTLE_CYCLES-1 + 1 cycles.

Test Plan:
- Nominal frame: drive digits 0..7 showing 8'h1,2,3,4,5,6,7,8 (digit k = k+1) with a 100-cycle dwell, SETTLE_CYCLES=16. Required: frame_pulse once after the 8th dwell; value=32'h87654321; frame_valid=1; digit_mask returns to 0.
- Full glyph sweep: run 16 frames where every digit shows nibble n=0..F. Required: value=32'hnnnnnnnn each frame; decode_error is never asserted.
- Glitch and short dwell:
  - Digit 3 held 10 cycles → no capture, digit_mask[3]=0.
  - Single-cycle seg_n glitch within a 100-cycle dwell → counter restarts and exactly one capture occurs.
- Bad pattern and invalid anode:
  - seg_n=7'b1111110 (only CA lit) on digit 2 → one decode_error pulse, digit_mask[2]=0.
  - an_n=8'hFC (two digits low) → no capture, no error.
- Timeout and overwrite:
  - Capture digits 0–5, then idle FRAME_TIMEOUT cycles (set to 500) → digit_mask=0, frame_valid=0, value unchanged.
  - Capture digit 1 twice as 4 then 9 within one frame → the completed value has nibble 1 = 9.
- Asynchronous reset: assert reset mid-dwell after 6 captures → all outputs are 0 immediately without a clock edge; the next full frame decodes correctly.

Source files
------------

// File: rtl/seven_seg_tdm_receiver.sv
// Receive side of an 8-digit multiplexed seven-segment display: samples the
// segment/anode lines, decodes each settled digit and reassembles the 32-bit value.
module seven_seg_tdm_receiver #(
    parameter int SETTLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [6:0]  seg_n,
    input  logic [7:0]  an_n,
    output logic [31:0] value,
    output logic        frame_valid,
    output logic        frame_pulse,
    output logic [7:0]  digit_mask,
    output logic        decode_error
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] FIRE_AT    = SW'(SETTLE_CYCLES - 2);
    localparam logic [TW-1:0] IDLE_MAX   = TW'(FRAME_TIMEOUT);

    logic [14:0] sync1_q, sync2_q, prev_q;
    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        pulse_q, pulse_d;
    logic        error_q, error_d;

    logic        same, an_valid, fire, capture_ok;
    logic [7:0]  an_lit;
    logic [2:0]  an_idx;
    logic [4:0]  decoded;

    // Returns {hit, nibble}; the pattern is the set of lit segments, bit 0 = CA.
    function automatic logic [4:0] decode_glyph(input logic [6:0] lit);
        case (lit)
            7'b0111111: decode_glyph = 5'h10;
            7'b0000110: decode_glyph = 5'h11;
            7'b1011011: decode_glyph = 5'h12;
            7'b1001111: decode_glyph = 5'h13;
            7'b1100110: decode_glyph = 5'h14;
            7'b1101101: decode_glyph = 5'h15;
            7'b1111101: decode_glyph = 5'h16;
            7'b0000111: decode_glyph = 5'h17;
            7'b1111111: decode_glyph = 5'h18;
            7'b1101111: decode_glyph = 5'h19;
            7'b1110111: decode_glyph = 5'h1A;
            7'b1111100: decode_glyph = 5'h1B;
            7'b0111001: decode_glyph = 5'h1C;
            7'b1011110: decode_glyph = 5'h1D;
            7'b1111001: decode_glyph = 5'h1E;
            7'b1110001: decode_glyph = 5'h1F;
            default:    decode_glyph = 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            idle_q   <= '0;
            digits_q <= '0;
            mask_q   <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            sync1_q  <= {seg_n, an_n};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stable_q <= stable_d;
            idle_q   <= idle_d;
            digits_q <= digits_d;
            mask_q   <= mask_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        an_lit   = ~sync2_q[7:0];
        an_valid = (an_lit != 8'h00) && ((an_lit & (an_lit - 8'h01)) == 8'h00);
        an_idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (an_lit[k]) begin
                an_idx = 3'(k);
            end
        end
        decoded = decode_glyph(~sync2_q[14:8]);

        same     = (sync2_q == prev_q);
        stable_d = '0;
        if (same) begin
            stable_d = (stable_q == SETTLE_MAX) ? stable_q : stable_q + SW'(1);
        end
        // Fire on the transition into SETTLE_CYCLES-1 so a saturated count never re-fires.
        fire       = same && (stable_q == FIRE_AT) && an_valid;
        capture_ok = fire && decoded[4];
    end

    always_comb begin
        digits_d = digits_q;
        mask_d   = mask_q;
        value_d  = value_q;
        valid_d  = valid_q;
        pulse_d  = 1'b0;
        error_d  = fire && !decoded[4];
        idle_d   = idle_q;

        if (capture_ok) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + TW'(1);
        end

        if (!capture_ok && (idle_q == IDLE_MAX - TW'(1))) begin
            mask_d  = '0;
            valid_d = 1'b0;
        end

        if (mask_q == 8'hFF) begin
            value_d = digits_q;
            valid_d = 1'b1;
            pulse_d = 1'b1;
            mask_d  = '0;
        end

        // Applied after the completion clear so a same-cycle capture opens the next frame.
        if (capture_ok) begin
            digits_d[4*an_idx +: 4] = decoded[3:0];
            mask_d[an_idx]          = 1'b1;
        end
    end

    assign value        = value_q;
    assign frame_valid  = valid_q;
    assign frame_pulse  = pulse_q;
    assign digit_mask   = mask_q;
    assign decode_error = error_q;

endmodule
